// File: rtl/digit_serial_adder_pkg.sv
// ----------------------------------------------------------------------------
// digit_serial_adder_pkg
//   Shared definitions for the digit-serial adder:
//     - state_e   : FSM state encoding (IDLE / RUN / DONE)
//     - cnt_width : width of the digit counter for N = WIDTH/DIGIT digits
//                   (at least one bit, so N = 1 still gets a real register)
// ----------------------------------------------------------------------------
package digit_serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int n);
    int w;
    if (n > 1) begin
      w = $clog2(n);
    end else begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/digit_serial_adder_ripple.sv
// ----------------------------------------------------------------------------
// dsa_full_adder
//   One-bit full adder cell.
//   Ports: a_i, b_i, c_i (inputs) -> s_o (sum), co_o (carry out)
//
// digit_ripple_adder
//   Purely combinational DIGIT-bit ripple-carry adder built from DIGIT
//   full-adder cells. Reused every clock by digit_serial_adder.
//   Ports:
//     x_i[DIGIT], y_i[DIGIT] : operand digits
//     ci_i                   : carry into bit 0
//     s_o[DIGIT]             : digit sum
//     co_o                   : carry out of the MSB
//     c_msb_in_o             : carry into the MSB (signed overflow detection)
// ----------------------------------------------------------------------------
module dsa_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i ^ c_i;
  assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module digit_ripple_adder #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x_i,
  input  logic [DIGIT-1:0] y_i,
  input  logic             ci_i,
  output logic [DIGIT-1:0] s_o,
  output logic             co_o,
  output logic             c_msb_in_o
);

  // c_s[k] is the carry into bit k; c_s[DIGIT] leaves the digit
  logic [DIGIT:0] c_s;

  assign c_s[0] = ci_i;

  for (genvar g = 0; g < DIGIT; g++) begin : g_fa
    dsa_full_adder u_fa (
      .a_i  (x_i[g]),
      .b_i  (y_i[g]),
      .c_i  (c_s[g]),
      .s_o  (s_o[g]),
      .co_o (c_s[g+1])
    );
  end

  assign co_o       = c_s[DIGIT];
  assign c_msb_in_o = c_s[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// ----------------------------------------------------------------------------
// digit_serial_adder
//   Adds or subtracts two WIDTH-bit operands DIGIT bits per clock using one
//   reused DIGIT-bit ripple adder and a registered carry. Start/done
//   handshake; latency WIDTH/DIGIT cycles from the accepting edge to done.
//
//   Ports:
//     clk_i          : rising-edge clock
//     rst_i          : synchronous active-high reset
//     start_i        : request, accepted in IDLE or DONE
//     a_i, b_i       : operands, latched on an accepted start
//     cin_i          : carry-in (add) / borrow-in (sub), latched on start
//     sub_i          : 0 = a+b+cin, 1 = a-b-cin, latched on start
//     busy_o         : high while digits are being processed
//     done_o         : one-cycle pulse, sum_o/cout_o valid
//     sum_o          : result, held until the next accepted start
//     cout_o         : carry-out (add) / NOT borrow-out (sub)
//     ovf_o          : signed overflow (only with DIGIT_SERIAL_ADDER_OVF_EN)
//
//   Build option: define DIGIT_SERIAL_ADDER_OVF_EN to add the ovf_o port.
// ----------------------------------------------------------------------------
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0]    LAST_CNT   = CW'(N - 1);
  localparam logic [WIDTH-1:0] DIGIT_MASK = WIDTH'({DIGIT{1'b1}});

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;     // already inverted for subtraction
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [31:0]       shamt_s;      // bit offset of the current digit
  logic [DIGIT-1:0]  dig_a_s;
  logic [DIGIT-1:0]  dig_b_s;
  logic [DIGIT-1:0]  dig_s_s;
  logic              dig_co_s;

`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  logic              c_msb_s;
  logic              ovf_q, ovf_d;
`else
  logic              c_msb_unused_s;
`endif

  assign shamt_s = 32'(cnt_q) * 32'(DIGIT);
  assign dig_a_s = DIGIT'(a_q >> shamt_s);
  assign dig_b_s = DIGIT'(b_q >> shamt_s);

  digit_ripple_adder #(.DIGIT(DIGIT)) u_ripple (
    .x_i        (dig_a_s),
    .y_i        (dig_b_s),
    .ci_i       (carry_q),
    .s_o        (dig_s_s),
    .co_o       (dig_co_s),
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    .c_msb_in_o (c_msb_s)
`else
    .c_msb_in_o (c_msb_unused_s)
`endif
  );

  // Next-state, datapath and output-register logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          a_d     = a_i;
          // a - b - cin == a + ~b + ~cin (mod 2^WIDTH)
          b_d     = sub_i ? ~b_i : b_i;
          carry_d = sub_i ? ~cin_i : cin_i;
          cnt_d   = {CW{1'b0}};
          state_d = ST_RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_d   = (sum_q & ~(DIGIT_MASK << shamt_s)) |
                  (WIDTH'(dig_s_s) << shamt_s);
        carry_d = dig_co_s;
        if (cnt_q == LAST_CNT) begin
          cnt_d   = {CW{1'b0}};
          cout_d  = dig_co_s;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
          ovf_d   = c_msb_s ^ dig_co_s;
`endif
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CW{1'b0}};
      carry_q <= 1'b0;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  // Signed overflow flag register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;
`endif

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule
